// File: rtl/udma_pkg.sv
// Shared datasize encodings, assembler state type and size helpers for the uDMA I2C RX packer.
package udma_pkg;

  localparam logic [1:0] DS_BYTE = 2'd0;
  localparam logic [1:0] DS_HALF = 2'd1;
  localparam logic [1:0] DS_WORD = 2'd2;

  typedef enum logic [1:0] {
    ASM_IDLE = 2'd0,
    ASM_FILL = 2'd1,
    ASM_FULL = 2'd2
  } asm_state_e;

  // Reserved encoding 3 behaves as a word; result never exceeds what the bus can carry.
  function automatic logic [1:0] ds_clamp(input logic [1:0] cfg, input logic [1:0] max_ds);
    logic [1:0] ds;
    ds = (cfg == 2'd3) ? DS_WORD : cfg;
    return (ds > max_ds) ? max_ds : ds;
  endfunction

  function automatic logic [2:0] ds_nbytes(input logic [1:0] ds);
    logic [2:0] n;
    case (ds)
      DS_BYTE: n = 3'd1;
      DS_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/udma_i2c_rx_fifo.sv
// Small register FIFO with wrap-bit pointers; a push into a full FIFO is allowed when a pop
// happens on the same edge.
module udma_i2c_rx_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and storage update; clear only rewinds the pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/udma_i2c_rx_packer.sv
// Packs I2C RX bytes little-endian into uDMA words and queues them in a small FIFO.
// Optional saturating pushed-word counter: define UDMA_I2C_RX_PACKER_STATS_EN.
module udma_i2c_rx_packer
  import udma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  sys_clk_i,
  input  logic                  rstn_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  cfg_clr_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic                  eot_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic [1:0]            rx_datasize_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o
`ifdef UDMA_I2C_RX_PACKER_STATS_EN
  ,
  output logic [15:0]           stat_words_o
`endif
);

  localparam int         NB     = DATA_WIDTH / 8;
  localparam logic [1:0] MAX_DS = (DATA_WIDTH == 8)  ? DS_BYTE :
                                  (DATA_WIDTH == 16) ? DS_HALF : DS_WORD;

  asm_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]            ds_q, ds_d;

  logic                  accept_s;
  logic                  complete_s;
  logic                  flush_s;
  logic                  can_push_s;
  logic                  push_s;
  logic                  pop_s;
  logic [1:0]            ds_cur_s;
  logic [DATA_WIDTH+1:0] push_data_s;
  logic [DATA_WIDTH+1:0] fifo_rdata_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;

  assign accept_s   = byte_valid_i && byte_ready_o;
  assign pop_s      = !fifo_empty_s && rx_ready_i;
  assign can_push_s = !fifo_full_s || pop_s;

  // Assembler state register.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ASM_IDLE;
      cnt_q   <= 3'd0;
      word_q  <= '0;
      ds_q    <= DS_BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ds_q    <= ds_d;
    end
  end

  // Next-state: byte insertion, completion/flush and the FIFO write decision.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    ds_d        = ds_q;
    push_s      = 1'b0;
    push_data_s = {ds_q, word_q};
    complete_s  = 1'b0;
    flush_s     = 1'b0;
    ds_cur_s    = (state_q == ASM_IDLE) ? ds_clamp(cfg_datasize_i, MAX_DS) : ds_q;
    if (cfg_clr_i) begin
      state_d = ASM_IDLE;
      cnt_d   = 3'd0;
      word_d  = '0;
      ds_d    = DS_BYTE;
    end else begin
      case (state_q)
        ASM_FULL: begin
          // Any end-of-transfer seen while holding a word is dropped: the word is already closed.
          if (can_push_s) begin
            push_s  = 1'b1;
            state_d = ASM_IDLE;
            cnt_d   = 3'd0;
            word_d  = '0;
          end else begin
            state_d = ASM_FULL;
          end
        end
        default: begin
          if (accept_s) begin
            for (int i = 0; i < NB; i++) begin
              if (cnt_q == 3'(i)) begin
                word_d[8*i +: 8] = byte_i;
              end else begin
                word_d[8*i +: 8] = word_q[8*i +: 8];
              end
            end
            cnt_d      = cnt_q + 3'd1;
            ds_d       = ds_cur_s;
            complete_s = ((cnt_q + 3'd1) == ds_nbytes(ds_cur_s));
          end else begin
            cnt_d = cnt_q;
          end
          flush_s     = !complete_s && eot_i && (cnt_d != 3'd0);
          push_data_s = {ds_d, word_d};
          if (complete_s || flush_s) begin
            if (can_push_s) begin
              push_s  = 1'b1;
              state_d = ASM_IDLE;
              cnt_d   = 3'd0;
              word_d  = '0;
            end else begin
              state_d = ASM_FULL;
            end
          end else if (cnt_d != 3'd0) begin
            state_d = ASM_FILL;
          end else begin
            state_d = ASM_IDLE;
          end
        end
      endcase
    end
  end

  // Handshake and status outputs.
  always_comb begin
    byte_ready_o = !cfg_clr_i && (state_q != ASM_FULL);
    busy_o       = (state_q != ASM_IDLE) || !fifo_empty_s;
  end

  assign rx_valid_o    = !fifo_empty_s;
  assign rx_data_o     = fifo_rdata_s[DATA_WIDTH-1:0];
  assign rx_datasize_o = fifo_rdata_s[DATA_WIDTH +: 2];

  udma_i2c_rx_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk_i),
    .rstn_i  (rstn_i),
    .clr_i   (cfg_clr_i),
    .push_i  (push_s),
    .wdata_i (push_data_s),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

`ifdef UDMA_I2C_RX_PACKER_STATS_EN
  logic [15:0] stat_q, stat_d;

  // Saturating count of words written into the FIFO.
  always_comb begin
    stat_d = stat_q;
    if (cfg_clr_i) begin
      stat_d = 16'd0;
    end else if (push_s && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end else begin
      stat_d = stat_q;
    end
  end

  // Counter register.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stat_q <= 16'd0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_words_o = stat_q;
`endif

endmodule

// File: tb/tb_udma_i2c_rx_packer.sv
// Randomized and directed bench for udma_i2c_rx_packer against a queue-based word model.
module tb_udma_i2c_rx_packer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [1:0]  cfg_datasize_i;
  logic        cfg_clr_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        eot_i;
  logic [31:0] rx_data_o;
  logic [1:0]  rx_datasize_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        busy_o;

  logic [1:0]  s16_ds;
  logic        s16_clr;
  logic [7:0]  s16_byte;
  logic        s16_vld;
  logic        s16_rdy_o;
  logic        s16_eot;
  logic [15:0] s16_data;
  logic [1:0]  s16_dsz;
  logic        s16_valid;
  logic        s16_ready_i;
  logic        s16_busy;
`ifdef UDMA_I2C_RX_PACKER_STATS_EN
  logic [15:0] stat_words_o;
  logic [15:0] s16_stat;
`endif

  always #5 clk = ~clk;

  udma_i2c_rx_packer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk_i      (clk),
    .rstn_i         (rstn_i),
    .cfg_datasize_i (cfg_datasize_i),
    .cfg_clr_i      (cfg_clr_i),
    .byte_i         (byte_i),
    .byte_valid_i   (byte_valid_i),
    .byte_ready_o   (byte_ready_o),
    .eot_i          (eot_i),
    .rx_data_o      (rx_data_o),
    .rx_datasize_o  (rx_datasize_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready_i),
    .busy_o         (busy_o)
`ifdef UDMA_I2C_RX_PACKER_STATS_EN
    ,
    .stat_words_o   (stat_words_o)
`endif
  );

  udma_i2c_rx_packer #(.DATA_WIDTH(16), .FIFO_DEPTH(2)) dut16 (
    .sys_clk_i      (clk),
    .rstn_i         (rstn_i),
    .cfg_datasize_i (s16_ds),
    .cfg_clr_i      (s16_clr),
    .byte_i         (s16_byte),
    .byte_valid_i   (s16_vld),
    .byte_ready_o   (s16_rdy_o),
    .eot_i          (s16_eot),
    .rx_data_o      (s16_data),
    .rx_datasize_o  (s16_dsz),
    .rx_valid_o     (s16_valid),
    .rx_ready_i     (s16_ready_i),
    .busy_o         (s16_busy)
`ifdef UDMA_I2C_RX_PACKER_STATS_EN
    ,
    .stat_words_o   (s16_stat)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: bytes of the open word, and closed words not yet consumed by the channel.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  ds;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] pend_q[$];
  int         cur_bytes = 1;
  int         emitted   = 0;

  function automatic int eff_bytes(input logic [1:0] ds, input int dw);
    int b;
    b = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
    if (b > dw / 8) b = dw / 8;
    return b;
  endfunction

  task automatic emit();
    word_t w;
    w.data = 32'd0;
    for (int i = 0; i < pend_q.size(); i++) w.data = w.data | (32'(pend_q[i]) << (8 * i));
    w.ds = (cur_bytes == 1) ? 2'd0 : (cur_bytes == 2) ? 2'd1 : 2'd2;
    exp_q.push_back(w);
    pend_q.delete();
    emitted++;
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_q.delete();
    emitted = 0;
  endtask

  // One clock cycle: drive at the falling edge, check the current outputs, advance the model.
  task automatic step(input logic vld, input logic [7:0] b, input logic eot,
                      input logic rdy, input logic [1:0] ds, input logic clr);
    logic exp_ready;
    logic acc;
    logic pop;
    int   held;
    byte_valid_i   = vld;
    byte_i         = b;
    eot_i          = eot;
    rx_ready_i     = rdy;
    cfg_datasize_i = ds;
    cfg_clr_i      = clr;
    #1;
    exp_ready = !clr && (exp_q.size() <= DEPTH);
    check_eq("byte_ready", 32'(byte_ready_o), 32'(exp_ready));
    check_eq("rx_valid", 32'(rx_valid_o), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_eq("rx_data", rx_data_o, exp_q[0].data);
      check_eq("rx_datasize", 32'(rx_datasize_o), 32'(exp_q[0].ds));
    end
    check_eq("busy", 32'(busy_o), 32'((exp_q.size() > 0) || (pend_q.size() > 0)));
    held = (exp_q.size() > DEPTH) ? 1 : 0;
`ifdef UDMA_I2C_RX_PACKER_STATS_EN
    check_eq("stat_words", 32'(stat_words_o), 32'((emitted - held > 65535) ? 65535 : emitted - held));
`endif
    acc = vld && exp_ready;
    pop = rdy && (exp_q.size() > 0);
    if (clr) begin
      model_clear();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        if (pend_q.size() == 0) cur_bytes = eff_bytes(ds, DW);
        pend_q.push_back(b);
        if (pend_q.size() == cur_bytes) emit();
      end
      if (eot && (pend_q.size() > 0)) emit();
    end
    @(negedge clk);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(byte_ready_o), 32'd1);
    check_eq({tag, "_valid"}, 32'(rx_valid_o), 32'd0);
    check_eq({tag, "_data"}, rx_data_o, 32'd0);
    check_eq({tag, "_ds"}, 32'(rx_datasize_o), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
`ifdef UDMA_I2C_RX_PACKER_STATS_EN
    check_eq({tag, "_stat"}, 32'(stat_words_o), 32'd0);
`endif
  endtask

  logic [7:0] b16 [4];
  logic [1:0] rnd_ds;
  logic       rnd_rdy;

  initial begin
    rstn_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00; eot_i = 1'b0;
    rx_ready_i = 1'b0; cfg_datasize_i = 2'd0; cfg_clr_i = 1'b0;
    s16_ds = 2'd2; s16_clr = 1'b0; s16_byte = 8'h00; s16_vld = 1'b0;
    s16_eot = 1'b0; s16_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rstn_i = 1'b1;
    @(negedge clk);

    // Full 4-byte word, one-cycle latency.
    step(1'b1, 8'h11, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b1, 2'd2, 1'b0);
    check_eq("w32_valid", 32'(rx_valid_o), 32'd1);
    check_eq("w32_data", rx_data_o, 32'h44332211);
    check_eq("w32_ds", 32'(rx_datasize_o), 32'd2);
    drain(2);

    // Halfword packing with end-of-transfer on the third byte.
    step(1'b1, 8'hAA, 1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b1, 8'hCC, 1'b1, 1'b0, 2'd1, 1'b0);
    check_eq("eot_w0", rx_data_o, 32'h0000BBAA);
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0);
    check_eq("eot_w1", rx_data_o, 32'h000000CC);
    check_eq("eot_w1_ds", 32'(rx_datasize_o), 32'd1);
    drain(2);

    // Backpressure: four bytes fill the FIFO, the fifth is held, the sixth waits for a pop.
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 2'd0, 1'b0);
    check_eq("bp_ready_low", 32'(byte_ready_o), 32'd0);
    step(1'b1, 8'h06, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h06, 1'b0, 1'b1, 2'd0, 1'b0);
    check_eq("bp_ready_after_pop", 32'(byte_ready_o), 32'd1);
    step(1'b1, 8'h06, 1'b0, 1'b0, 2'd0, 1'b0);
    drain(7);
    check_eq("bp_drained_busy", 32'(busy_o), 32'd0);

    // Clear with two words queued and one byte pending.
    step(1'b1, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h5B, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h5C, 1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
    check_eq("clr_valid", 32'(rx_valid_o), 32'd0);
    check_eq("clr_busy", 32'(busy_o), 32'd0);
    drain(1);

    // Reset asserted mid-word discards the partial word.
    step(1'b1, 8'h77, 1'b0, 1'b0, 2'd2, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0, 2'd2, 1'b0);
    byte_valid_i = 1'b0; eot_i = 1'b0; cfg_clr_i = 1'b0; rx_ready_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    check_reset_outputs("midword_reset");
    model_clear();
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);

    // Randomized traffic with alternating backpressure phases.
    rnd_ds = 2'd2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rnd_ds = 2'($urandom_range(0, 3));
      rnd_rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
           rnd_rdy, rnd_ds, $urandom_range(0, 199) == 0);
    end
    drain(12);
    check_eq("final_busy", 32'(busy_o), 32'd0);

    // 16-bit instance: word requests clamp to halfwords.
    b16[0] = 8'h11; b16[1] = 8'h22; b16[2] = 8'h33; b16[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      s16_vld = 1'b1; s16_byte = b16[k]; s16_ds = 2'd2; s16_ready_i = 1'b1;
      @(negedge clk);
      if (k == 1) begin
        check_eq("w16_valid0", 32'(s16_valid), 32'd1);
        check_eq("w16_data0", 32'(s16_data), 32'h2211);
        check_eq("w16_ds0", 32'(s16_dsz), 32'd1);
      end
      if (k == 3) begin
        check_eq("w16_data1", 32'(s16_data), 32'h4433);
        check_eq("w16_ds1", 32'(s16_dsz), 32'd1);
      end
    end
    s16_vld = 1'b0;
    @(negedge clk);
    check_eq("w16_empty", 32'(s16_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
